bep_pulse_decoder: RTL and testbench
====================================

// Module: bep_pulse_decoder
// PURPOSE
//  Pulse-width bit decoder fed by the single-line edge detector's pos_edge/neg_edge strobes.
//  Times each high pulse: >= BIT_THRESH cycles is a 1, shorter is a 0.
//  Assembles FRAME_BITS bits MSB-first and hands each word downstream on a valid/ready port.
//  Ends a frame after IDLE_TIMEOUT low cycles.
// PARAMETERS
//  CNT_W        12    pulse timer width; timer saturates at 2**CNT_W-1
//  BIT_THRESH   400   high width (cycles) at or above which bit=1
//  IDLE_TIMEOUT 2000  low width (cycles) that ends a frame; must be < 2**CNT_W
//  FRAME_BITS   8     bits per output word
//  MIN_PULSE    16    glitch limit; only used with BEP_GLITCH_FILTER_EN
// PORTS
//  clock       in   1           system clock, all logic on posedge
//  reset_n     in   1           synchronous, active-low reset
//  enable      in   1           0: FSM forced to IDLE, timer and bit count cleared
//  pos_edge    in   1           rising-edge strobe from edge detector
//  neg_edge    in   1           falling-edge strobe from edge detector
//  data        out  FRAME_BITS  decoded word, stable while data_valid=1
//  data_valid  out  1           word available
//  data_ready  in   1           consumer accepts on data_valid & data_ready
//  frame_end   out  1           one-cycle pulse on idle timeout
//  overrun     out  1           sticky: a completed word was dropped
//  err_clear   in   1           clears overrun
// BEHAVIOUR
//  Reset: state=IDLE, timer=0, bit_cnt=0, shreg=0, data=0, data_valid=0, frame_end=0, overrun=0.
//  States (IDLE, HIGH, LOW):
//   IDLE: timer=0. pos_edge -> HIGH, timer=1.
//   HIGH: timer++ (saturating). On neg_edge, classify width = timer.
//    - Bit = (timer >= BIT_THRESH). Shift into shreg LSB; earlier bits move up (MSB-first).
//    - bit_cnt++. Go to LOW, timer=1.
//    - A pos_edge arriving while in HIGH is ignored.
//   LOW: timer++. pos_edge -> HIGH, timer=1.
//    - timer==IDLE_TIMEOUT with no pos_edge -> IDLE; frame_end=1 next cycle.
//    - On that timeout, partial bits are discarded (bit_cnt=0); no word is emitted.
//  Width = N exactly when neg_edge arrives N cycles after pos_edge.
//  pos_edge & neg_edge in the same cycle: both ignored, no state change.
//  Word completion: neg_edge that makes bit_cnt==FRAME_BITS.
//   - bit_cnt returns to 0.
//   - data and data_valid update the following cycle: latency 1 from the last neg_edge.
//  Handshake:
//   - data_valid holds until a data_valid & data_ready cycle; data is stable meanwhile.
//   - Completion while data_valid=1 and data_ready=0: new word dropped, old word kept, overrun=1.
//   - Completion in the same cycle as an accept: new word loaded, data_valid stays 1, no overrun.
//  overrun: cleared by err_clear. If err_clear and a new overrun coincide, set wins.
//  enable=0 (any cycle, mid-pulse included):
//   - state=IDLE, timer=0, bit_cnt=0; partial bits lost.
//   - data, data_valid and overrun are held; the handshake still operates.
//  Reset mid-frame: all state returns to reset values on the next edge; a pending word is lost.
// CONFIGURATION
//  BEP_GLITCH_FILTER_EN defined:
//   - neg_edge in HIGH with timer < MIN_PULSE produces no bit; bit_cnt is unchanged.
//   - State goes to LOW with timer=1.
//  Not defined: every high pulse yields a bit; MIN_PULSE is unused.
// STRUCTURE
//  bep_pkg holds: state enum (IDLE/HIGH/LOW); default constants for CNT_W, BIT_THRESH,
//   IDLE_TIMEOUT, FRAME_BITS, MIN_PULSE.
//  Sub-module pulse_timer: CNT_W saturating counter with clear/load-1/increment controls,
//   shared by the HIGH and LOW states.
//  FSM, shift register and output/handshake register live in the top module.
// TESTING
//  1. Pulses 600,200,600,200,600,200,600,200 high, 300 low, data_ready=1
//     -> data=8'hAA, data_valid for 1 cycle, 1 cycle after the 8th neg_edge.
//  2. Widths 399 and 400 -> bits 0 and 1 respectively (threshold boundary).
//  3. 3 bits sent, then line low 2000 cycles -> frame_end pulse; no data_valid;
//     next 8 bits decode correctly from bit 0.
//  4. data_ready=0; send 2 words -> first word held, overrun=1;
//     err_clear -> overrun=0; data_ready=1 -> first word accepted.
//  5. enable=0 for 1 cycle after 5 bits -> FSM to IDLE;
//     a following full word decodes without stale bits.
//  6. BEP_GLITCH_FILTER_EN: a 10-cycle high pulse between valid bits -> ignored,
//     word unchanged; without the macro -> extra 0 bit shifted in.

Source files
------------

// File: rtl/bep_pkg.sv
// Shared types and default constants for the pulse-width bit decoder.
// Holds the FSM state enum and the parameter defaults used by the top.
package bep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int CNT_W_DEF        = 12;
    localparam int BIT_THRESH_DEF   = 400;
    localparam int IDLE_TIMEOUT_DEF = 2000;
    localparam int FRAME_BITS_DEF   = 8;
    localparam int MIN_PULSE_DEF    = 16;

endpackage

// File: rtl/bep_pulse_decoder_pulse_timer.sv
// Saturating pulse timer shared by the HIGH and LOW phases.
// Ports: clock, reset_n (sync, active-low), clr/load1/inc controls
// (priority clr > load1 > inc), count = current timer value.
module pulse_timer #(
    parameter int CNT_W = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load1) begin
            count_d = CNT_W'(1);
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bep_pulse_decoder.sv
// Pulse-width bit decoder: times high pulses from edge strobes, builds
// MSB-first words and offers them on a valid/ready port.
// Ports: clock, reset_n (sync, active-low), enable, pos_edge, neg_edge,
// data/data_valid/data_ready (output handshake), frame_end (idle timeout
// pulse), overrun (sticky drop flag), err_clear (clears overrun).
// Build option: BEP_GLITCH_FILTER_EN drops high pulses shorter than MIN_PULSE.
module bep_pulse_decoder
    import bep_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int BIT_THRESH   = BIT_THRESH_DEF,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter int FRAME_BITS   = FRAME_BITS_DEF,
    parameter int MIN_PULSE    = MIN_PULSE_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  pos_edge,
    input  logic                  neg_edge,
    output logic [FRAME_BITS-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  frame_end,
    output logic                  overrun,
    input  logic                  err_clear
);

    localparam int BC_W = $clog2(FRAME_BITS + 1);

`ifdef BEP_GLITCH_FILTER_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    state_t state_d;
    state_t state_q;

    logic [CNT_W-1:0]      timer_q;
    logic                  tmr_clr;
    logic                  tmr_load;
    logic                  tmr_inc;

    logic [BC_W-1:0]       bit_cnt_d;
    logic [BC_W-1:0]       bit_cnt_q;
    logic [FRAME_BITS-1:0] shreg_d;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [FRAME_BITS-1:0] data_d;
    logic [FRAME_BITS-1:0] data_q;
    logic                  data_valid_d;
    logic                  data_valid_q;
    logic                  frame_end_d;
    logic                  frame_end_q;
    logic                  overrun_d;
    logic                  overrun_q;

    logic pe;
    logic ne;
    logic timeout;
    logic short_pulse;
    logic bit_stb;
    logic cnt_clr;
    logic bit_val;
    logic word_done;
    logic accept;
    logic ovr_set;

    // Coincident strobes cancel each other out.
    assign pe          = pos_edge & ~neg_edge;
    assign ne          = neg_edge & ~pos_edge;
    assign timeout     = (timer_q == CNT_W'(IDLE_TIMEOUT));
    assign short_pulse = GLITCH_EN & (timer_q < CNT_W'(MIN_PULSE));
    assign bit_val     = (timer_q >= CNT_W'(BIT_THRESH));

    pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .load1   (tmr_load),
        .inc     (tmr_inc),
        .count   (timer_q)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (pe) state_d = ST_HIGH;
                ST_HIGH: if (ne) state_d = ST_LOW;
                ST_LOW: begin
                    if (pe) begin
                        state_d = ST_HIGH;
                    end else if (timeout) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tmr_clr     = 1'b0;
        tmr_load    = 1'b0;
        tmr_inc     = 1'b0;
        bit_stb     = 1'b0;
        cnt_clr     = 1'b0;
        frame_end_d = 1'b0;
        if (!enable) begin
            tmr_clr = 1'b1;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pe) tmr_load = 1'b1;
                    else    tmr_clr  = 1'b1;
                end
                ST_HIGH: begin
                    if (ne) begin
                        tmr_load = 1'b1;
                        bit_stb  = ~short_pulse;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (pe) begin
                        tmr_load = 1'b1;
                    end else if (timeout) begin
                        tmr_clr     = 1'b1;
                        cnt_clr     = 1'b1;
                        frame_end_d = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                default: tmr_clr = 1'b1;
            endcase
        end
    end

    // Shift register: new bit enters at the LSB so the first bit ends up MSB.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        word_done = 1'b0;
        if (cnt_clr) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (bit_stb) begin
            shreg_d = (shreg_q << 1) | FRAME_BITS'(bit_val);
            if (bit_cnt_q == BC_W'(FRAME_BITS - 1)) begin
                word_done = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
        end
    end

    // A word may load when the slot is empty or being emptied this cycle.
    always_comb begin
        accept       = data_valid_q & data_ready;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        ovr_set      = 1'b0;
        if (word_done) begin
            if (!data_valid_q || accept) begin
                data_d       = shreg_d;
                data_valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (accept) begin
            data_valid_d = 1'b0;
        end
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (err_clear) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_end_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_end_q  <= frame_end_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_end  = frame_end_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_bep_pulse_decoder.sv
// Scoreboard bench for bep_pulse_decoder: directed pulse trains push
// expected words; a negedge monitor pops and checks on each accept.
module tb_bep_pulse_decoder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       pos_edge = 1'b0;
    logic       neg_edge = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       frame_end;
    logic       overrun;
    logic       err_clear = 1'b0;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    bep_pulse_decoder dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_end  (frame_end),
        .overrun    (overrun),
        .err_clear  (err_clear)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset_n && frame_end) fe_cnt++;
        if (reset_n && data_valid && data_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got %0h want none", data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    bad++;
                    $display("FAIL word: got %0h want %0h", data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // High for hi cycles (width hi), then low for lo cycles before the next strobe.
    task automatic send_pulse(int hi, int lo, bit lat_chk);
        pos_edge = 1'b1;
        step();
        pos_edge = 1'b0;
        repeat (hi - 1) step();
        neg_edge = 1'b1;
        step();
        neg_edge = 1'b0;
        if (lat_chk) begin
            check("valid_latency", 32'(data_valid), 32'd1);
            step();
            check("valid_one_cycle", 32'(data_valid), 32'd0);
            repeat (lo - 2) step();
        end else begin
            repeat (lo - 1) step();
        end
    endtask

    task automatic send_word(logic [7:0] w, bit push);
        if (push) exp_q.push_back(w);
        for (int i = 7; i >= 0; i--) begin
            send_pulse(w[i] ? 600 : 200, 50, 1'b0);
        end
    endtask

    initial begin
        repeat (3) step();
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_frame_end", 32'(frame_end), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        enable = 1'b1;
        step();

        // 1: alternating widths -> AA, one-cycle valid one cycle after last neg_edge
        data_ready = 1'b1;
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 7; i++) begin
            send_pulse((i % 2 == 0) ? 600 : 200, 300, 1'b0);
        end
        send_pulse(200, 300, 1'b1);

        // 2: threshold boundary 399 -> 0, 400 -> 1
        exp_q.push_back(8'h57);
        send_pulse(399, 50, 1'b0);
        send_pulse(400, 50, 1'b0);
        send_pulse(399, 50, 1'b0);
        send_pulse(400, 50, 1'b0);
        send_pulse(399, 50, 1'b0);
        send_pulse(400, 50, 1'b0);
        send_pulse(400, 50, 1'b0);
        send_pulse(400, 50, 1'b0);

        // 3: partial frame then idle timeout
        send_pulse(600, 50, 1'b0);
        send_pulse(600, 50, 1'b0);
        send_pulse(200, 50, 1'b0);
        repeat (2100) step();
        check("timeout_frame_end", 32'(fe_cnt), 32'd1);
        check("timeout_no_word", 32'(exp_q.size()), 32'd0);
        send_word(8'h3C, 1'b1);

        // 4: back-pressure and overrun
        data_ready = 1'b0;
        send_word(8'hF0, 1'b0);
        send_word(8'h0F, 1'b0);
        check("ovr_valid_held", 32'(data_valid), 32'd1);
        check("ovr_data_held", 32'(data), 32'hF0);
        check("ovr_flag", 32'(overrun), 32'd1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        exp_q.push_back(8'hF0);
        data_ready = 1'b1;
        repeat (3) step();
        check("ovr_accepted", 32'(data_valid), 32'd0);
        check("ovr_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: enable drop mid-frame discards partial bits
        for (int i = 0; i < 5; i++) send_pulse(600, 50, 1'b0);
        enable = 1'b0;
        step();
        enable = 1'b1;
        repeat (20) step();
        send_word(8'h81, 1'b1);

        // 6: short glitch pulse between valid bits
`ifdef BEP_GLITCH_FILTER_EN
        exp_q.push_back(8'hAA);
`else
        exp_q.push_back(8'h95);
`endif
        send_pulse(600, 50, 1'b0);
        send_pulse(200, 50, 1'b0);
        send_pulse(10, 50, 1'b0);
        send_pulse(600, 50, 1'b0);
        send_pulse(200, 50, 1'b0);
        send_pulse(600, 50, 1'b0);
        send_pulse(200, 50, 1'b0);
        send_pulse(600, 50, 1'b0);
        send_pulse(200, 50, 1'b0);
        repeat (2100) step();
        check("glitch_frame_end", 32'(fe_cnt), 32'd2);

        repeat (5) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_overrun", 32'(overrun), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
